// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MEM stage: word/half/byte stores with
// sign/zero-extended loads, misalign/range detection and commit counting.
module dm_bytelane #(
    parameter int DEPTH  = 3072,
    parameter int AW     = 14,
    parameter int LOG_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc,
    input  logic          MemWrite,
    input  logic [2:0]    mem_op,
    input  logic [AW-1:0] address,
    input  logic [31:0]   data,
    output logic [31:0]   out,
    output logic          misalign,
    output logic          out_of_range,
    output logic          err_sticky,
    output logic [31:0]   wr_count
);

    localparam int WW = AW - 2;

    logic [31:0]   mem_q [DEPTH];
    logic          err_q;
    logic          err_d;
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_d;

    logic [WW-1:0] widx;
    logic [1:0]    lane;
    logic          is_half;
    logic          is_byte;
    logic          is_sgn;
    logic [31:0]   rd_word;
    logic [31:0]   rd_sh;
    logic [31:0]   wmask;
    logic [31:0]   wdata;
    logic [31:0]   merged;
    logic          commit;
    logic          reject;

    assign widx = address[AW-1:2];
    assign lane = address[1:0];

    always_comb begin
        is_half = 1'b0;
        is_byte = 1'b0;
        is_sgn  = 1'b0;
        case (mem_op)
            3'b001:  is_half = 1'b1;
            3'b010: begin
                is_half = 1'b1;
                is_sgn  = 1'b1;
            end
            3'b011:  is_byte = 1'b1;
            3'b100: begin
                is_byte = 1'b1;
                is_sgn  = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_of_range = ({{(32-WW){1'b0}}, widx} >= 32'(DEPTH));

    always_comb begin
        misalign = 1'b0;
        if (is_half)
            misalign = lane[0];
        else if (!is_byte)
            misalign = |lane;
    end

    assign rd_word = out_of_range ? 32'h0 : mem_q[widx];
    assign rd_sh   = rd_word >> {lane, 3'b000};

    always_comb begin
        out = rd_word;
        if (misalign || out_of_range)
            out = 32'h0;
        else if (is_half)
            out = {{16{is_sgn & rd_sh[15]}}, rd_sh[15:0]};
        else if (is_byte)
            out = {{24{is_sgn & rd_sh[7]}}, rd_sh[7:0]};
    end

    // Lanes are positioned by the byte offset; aligned halves have lane[0]=0.
    always_comb begin
        wmask = 32'hFFFF_FFFF;
        wdata = data;
        if (is_half) begin
            wmask = 32'h0000_FFFF << {lane, 3'b000};
            wdata = {16'h0, data[15:0]} << {lane, 3'b000};
        end else if (is_byte) begin
            wmask = 32'h0000_00FF << {lane, 3'b000};
            wdata = {24'h0, data[7:0]} << {lane, 3'b000};
        end
    end

    assign merged = (rd_word & ~wmask) | (wdata & wmask);
    assign commit = MemWrite & ~misalign & ~out_of_range;
    assign reject = MemWrite & (misalign | out_of_range);

    assign err_d = err_q | reject;
    assign cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 32'h0;
        end else if (commit) begin
            mem_q[widx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            cnt_q <= 32'h0;
        end else begin
            err_q <= err_d;
            if (commit)
                cnt_q <= cnt_d;
        end
    end

    assign err_sticky = err_q;
    assign wr_count   = cnt_q;

`ifndef SYNTHESIS
    if (LOG_EN != 0) begin : g_log
        always @(posedge clk) begin
            if (reset && commit)
                $display("%d@%h: *%h <= %h", $time, pc,
                         {widx, 2'b00}, merged);
        end
    end
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Randomised and directed bench for dm_bytelane against a byte-array
// reference model; outputs are compared at every falling clock edge.
module tb_dm_bytelane;

    localparam int DEPTH = 3072;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   pc = 32'h0;
    logic          MemWrite = 1'b0;
    logic [2:0]    mem_op = 3'b000;
    logic [AW-1:0] address = '0;
    logic [31:0]   data = 32'h0;
    logic [31:0]   out;
    logic          misalign;
    logic          out_of_range;
    logic          err_sticky;
    logic [31:0]   wr_count;

    int checks = 0;
    int errors = 0;

    dm_bytelane #(.DEPTH(DEPTH), .AW(AW), .LOG_EN(1)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .MemWrite(MemWrite),
        .mem_op(mem_op),
        .address(address),
        .data(data),
        .out(out),
        .misalign(misalign),
        .out_of_range(out_of_range),
        .err_sticky(err_sticky),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: flat little-endian byte array.
    logic [7:0]  mem_m [4*DEPTH];
    logic        m_err;
    logic [31:0] m_cnt;

    function automatic int msize(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 2;
        if (op == 3'd3 || op == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit m_oor(input logic [AW-1:0] a);
        return (int'(a) / 4) >= DEPTH;
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input logic [AW-1:0] a);
        return (int'(a) % msize(op)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op,
                                           input logic [AW-1:0] a);
        logic [31:0] v;
        logic [31:0] ones;
        int sz;
        sz = msize(op);
        v = 32'h0;
        ones = 32'hFFFF_FFFF;
        if (m_oor(a) || m_mis(op, a)) return 32'h0;
        for (int i = 0; i < sz; i++)
            v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
        if ((op == 3'd2 || op == 3'd4) && v[8*sz-1])
            v = v | (ones << (8 * sz));
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4*DEPTH; i++)
                mem_m[i] <= 8'h0;
            m_err <= 1'b0;
            m_cnt <= 32'h0;
        end else if (MemWrite) begin
            if (m_oor(address) || m_mis(mem_op, address)) begin
                m_err <= 1'b1;
            end else begin
                for (int i = 0; i < msize(mem_op); i++)
                    mem_m[int'(address) + i] <= data[8*i +: 8];
                if (m_cnt != 32'hFFFF_FFFF)
                    m_cnt <= m_cnt + 32'd1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("out", out, m_load(mem_op, address));
        chk("misalign", 32'(misalign), 32'(m_mis(mem_op, address)));
        chk("out_of_range", 32'(out_of_range), 32'(m_oor(address)));
        chk("err_sticky", 32'(err_sticky), 32'(m_err));
        chk("wr_count", wr_count, m_cnt);
    end

    task automatic cyc(input logic we, input logic [2:0] op,
                       input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        MemWrite = we;
        mem_op   = op;
        address  = a;
        data     = d;
        pc       = pc + 32'd4;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int r;
        reset = 1'b0;
        #100;
        @(posedge clk);
        #1;
        reset = 1'b1;

        cyc(0, 3'd0, 14'd0, 32'h0);
        chk("lit_rst_out0", out, 32'h0);
        chk("lit_rst_err", 32'(err_sticky), 32'h0);
        chk("lit_rst_cnt", wr_count, 32'h0);
        cyc(0, 3'd0, 14'd200, 32'h0);
        chk("lit_rst_out200", out, 32'h0);
        cyc(0, 3'd0, 14'd12284, 32'h0);
        chk("lit_rst_out12284", out, 32'h0);

        cyc(1, 3'd0, 14'd200, 32'h0000_0032);
        cyc(0, 3'd0, 14'd200, 32'h0);
        chk("lit_w200", out, 32'h0000_0032);
        chk("lit_w200_cnt", wr_count, 32'd1);

        cyc(1, 3'd0, 14'd0, 32'h1122_3344);
        cyc(1, 3'd3, 14'd2, 32'h0000_00AB);
        cyc(0, 3'd0, 14'd0, 32'h0);
        chk("lit_merge_w", out, 32'h11AB_3344);
        cyc(0, 3'd4, 14'd2, 32'h0);
        chk("lit_lb", out, 32'hFFFF_FFAB);
        cyc(0, 3'd3, 14'd2, 32'h0);
        chk("lit_lbu", out, 32'h0000_00AB);
        cyc(0, 3'd2, 14'd2, 32'h0);
        chk("lit_lh", out, 32'h0000_11AB);

        cyc(1, 3'd0, 14'h1FFC, 32'hA5A5_A5A5);
        cyc(1, 3'd0, 14'd12284, 32'h5A5A_5A5A);
        cyc(1, 3'd0, 14'd12288, 32'hDEAD_BEEF);
        chk("lit_oor", 32'(out_of_range), 32'h1);
        cyc(0, 3'd0, 14'd12284, 32'h0);
        chk("lit_last", out, 32'h5A5A_5A5A);
        chk("lit_oor_cnt", wr_count, 32'd5);
        chk("lit_oor_err", 32'(err_sticky), 32'h1);

        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("lit_rst2_cnt", wr_count, 32'h0);
        chk("lit_rst2_err", 32'(err_sticky), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        cyc(1, 3'd1, 14'd1, 32'h0000_FFFF);
        chk("lit_mis_h", 32'(misalign), 32'h1);
        cyc(1, 3'd0, 14'd6, 32'h1234_5678);
        chk("lit_mis_w", 32'(misalign), 32'h1);
        chk("lit_mis_err", 32'(err_sticky), 32'h1);
        cyc(0, 3'd0, 14'd4, 32'h0);
        chk("lit_mis_mem", out, 32'h0);
        cyc(1, 3'd0, 14'd8, 32'h0000_0077);
        cyc(0, 3'd0, 14'd8, 32'h0);
        chk("lit_valid_after", out, 32'h0000_0077);
        chk("lit_err_stays", 32'(err_sticky), 32'h1);

        cyc(1, 3'd3, 14'd0, 32'h0000_0011);
        cyc(1, 3'd3, 14'd1, 32'h0000_0022);
        cyc(1, 3'd1, 14'd2, 32'h0000_4433);
        cyc(0, 3'd0, 14'd0, 32'h0);
        chk("lit_b2b_merge", out, 32'h4433_2211);

        for (int k = 0; k < 4; k++) begin
            cyc(1, 3'd0, 14'd0, 32'(k + 1));
            cyc(1, 3'd0, 14'd4, 32'(k + 16));
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b1;
        mem_op   = 3'd0;
        address  = 14'd0;
        data     = 32'h0000_CAFE;
        #1;
        chk("lit_pulse_mem", out, 32'h0);
        chk("lit_pulse_cnt", wr_count, 32'h0);
        #2;
        reset = 1'b1;
        cyc(0, 3'd0, 14'd0, 32'h0);
        chk("lit_post_pulse", out, 32'h0000_CAFE);
        chk("lit_post_cnt", wr_count, 32'd1);

        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1;
            r        = int'($urandom_range(0, 9));
            MemWrite = $urandom_range(0, 1) == 1;
            mem_op   = 3'($urandom_range(0, 7));
            data     = $urandom;
            pc       = pc + 32'd4;
            if (r < 6)
                address = AW'($urandom_range(0, 63));
            else if (r < 9)
                address = AW'($urandom_range(12256, 12316));
            else
                address = AW'($urandom_range(0, 16383));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                #3;
                reset = 1'b1;
            end
        end

        MemWrite = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
